// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the multiplier back-end: FSM state encoding and default widths
// common to the multiplier top and its product accumulator.
package product_accumulator_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int COUNT_W    = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / batch-sum-out handshake bundle of the product accumulator.
// The slave side is the accumulator; the master side drives products and consumes sums.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) ();

  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [PROD_W-1:0]  in_product;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic               out_ovf;
  logic [COUNT_W-1:0] count;

  modport master (
    output clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, count
  );

  modport slave (
    input  clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, count
  );

endinterface

// File: rtl/product_accumulator_signed_acc_add.sv
// Combinational two's-complement adder: wide accumulator plus sign-extended product,
// with signed overflow detection on the ACC_W-bit result.
module signed_acc_add #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W-1:0] b_ext;

  generate
    if (ACC_W > PROD_W) begin : g_ext
      assign b_ext = {{(ACC_W-PROD_W){b[PROD_W-1]}}, b};
    end else begin : g_same
      assign b_ext = b;
    end
  endgenerate

  always_comb begin
    sum = a + b_ext;
    // Overflow only when both operands share a sign and the result flips it.
    ovf = (a[ACC_W-1] == b_ext[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums NUM_PRODUCTS consecutive signed products and presents each batch sum over a
// valid/ready handshake, flagging any signed accumulator overflow within the batch.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W       = PROD_W_DEF,
  parameter int ACC_W        = ACC_W_DEF,
  parameter int NUM_PRODUCTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  product_accumulator_if.slave bus
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(NUM_PRODUCTS - 1);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum_next;
  logic               ovf;
  logic               add_ovf;
  logic               accept;
  logic [COUNT_W-1:0] cnt_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_sum_q;
  logic               out_ovf_q;

  signed_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .a   (acc),
    .b   (bus.in_product),
    .sum (sum_next),
    .ovf (add_ovf)
  );

  assign bus.in_ready  = (state == ST_ACCUM) && !bus.clear;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.count     = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ACCUM;
      acc         <= '0;
      cnt_q       <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      // out_sum/out_ovf keep their last presented value; only out_valid qualifies them.
      state       <= ST_ACCUM;
      acc         <= '0;
      cnt_q       <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc   <= sum_next;
            cnt_q <= cnt_q + 8'd1;
            ovf   <= ovf | add_ovf;
            if (cnt_q == LAST) begin
              state       <= ST_HOLD;
              out_valid_q <= 1'b1;
              out_sum_q   <= sum_next;
              out_ovf_q   <= ovf | add_ovf;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state       <= ST_ACCUM;
            acc         <= '0;
            cnt_q       <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three parameterisations driven by shared stimulus,
// each checked every cycle against an arithmetic batch model, plus literal spot checks.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_product;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(64), .ACC_W(72)) bus_a ();
  product_accumulator_if #(.PROD_W(64), .ACC_W(72)) bus_b ();
  product_accumulator_if #(.PROD_W(64), .ACC_W(64)) bus_c ();

  assign bus_a.clear = clear;  assign bus_a.in_valid = in_valid;
  assign bus_a.in_product = in_product;  assign bus_a.out_ready = out_ready;
  assign bus_b.clear = clear;  assign bus_b.in_valid = in_valid;
  assign bus_b.in_product = in_product;  assign bus_b.out_ready = out_ready;
  assign bus_c.clear = clear;  assign bus_c.in_valid = in_valid;
  assign bus_c.in_product = in_product;  assign bus_c.out_ready = out_ready;

  product_accumulator #(.PROD_W(64), .ACC_W(72), .NUM_PRODUCTS(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  product_accumulator #(.PROD_W(64), .ACC_W(72), .NUM_PRODUCTS(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  product_accumulator #(.PROD_W(64), .ACC_W(64), .NUM_PRODUCTS(2)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  logic [71:0] d_sum   [3];
  logic        d_valid [3];
  logic        d_ready [3];
  logic        d_ovf   [3];
  logic [7:0]  d_cnt   [3];

  assign d_sum[0] = bus_a.out_sum;  assign d_sum[1] = bus_b.out_sum;
  assign d_sum[2] = {8'h00, bus_c.out_sum};
  assign d_valid[0] = bus_a.out_valid;  assign d_valid[1] = bus_b.out_valid;
  assign d_valid[2] = bus_c.out_valid;
  assign d_ready[0] = bus_a.in_ready;  assign d_ready[1] = bus_b.in_ready;
  assign d_ready[2] = bus_c.in_ready;
  assign d_ovf[0] = bus_a.out_ovf;  assign d_ovf[1] = bus_b.out_ovf;
  assign d_ovf[2] = bus_c.out_ovf;
  assign d_cnt[0] = bus_a.count;  assign d_cnt[1] = bus_b.count;
  assign d_cnt[2] = bus_c.count;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int np_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int aw_of(input int i);
    return (i == 2) ? 64 : 72;
  endfunction

  // Reduce an exact integer to the signed value representable in w bits.
  function automatic logic signed [79:0] wrap(input logic signed [79:0] x, input int w);
    logic signed [79:0] t;
    t = x <<< (80 - w);
    return t >>> (80 - w);
  endfunction

  // Model: exact running sum per batch; overflow whenever the exact sum leaves the range.
  bit                 m_hold [3];
  int                 m_cnt  [3];
  logic signed [79:0] m_acc  [3];
  bit                 m_ovf  [3];
  logic signed [79:0] m_hsum [3];
  bit                 m_hovf [3];

  always @(posedge clk) begin : model
    logic signed [79:0] pe;
    logic signed [79:0] exact;
    logic signed [79:0] wr;
    pe = {{16{in_product[63]}}, in_product};
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_hold[i] = 1'b0; m_cnt[i] = 0; m_acc[i] = '0; m_ovf[i] = 1'b0;
        m_hsum[i] = '0;   m_hovf[i] = 1'b0;
      end else if (clear || (m_hold[i] && out_ready)) begin
        m_hold[i] = 1'b0; m_cnt[i] = 0; m_acc[i] = '0; m_ovf[i] = 1'b0;
      end else if (!m_hold[i] && in_valid) begin
        exact     = m_acc[i] + pe;
        wr        = wrap(exact, aw_of(i));
        m_ovf[i]  = m_ovf[i] | (wr != exact);
        m_acc[i]  = wr;
        m_cnt[i]  = m_cnt[i] + 1;
        if (m_cnt[i] == np_of(i)) begin
          m_hold[i] = 1'b1;
          m_hsum[i] = m_acc[i];
          m_hovf[i] = m_ovf[i];
        end
      end
    end
  end

  function automatic logic [71:0] exp_sum(input int i);
    logic [71:0] e;
    e = m_hsum[i][71:0];
    if (aw_of(i) == 64) e[71:64] = '0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("in_ready[%0d]", i), {71'b0, d_ready[i]},
              {71'b0, (!m_hold[i] && !clear)});
        check($sformatf("out_valid[%0d]", i), {71'b0, d_valid[i]}, {71'b0, m_hold[i]});
        check($sformatf("count[%0d]", i), {64'b0, d_cnt[i]}, 72'(m_cnt[i]));
        check($sformatf("out_sum[%0d]", i), d_sum[i], exp_sum(i));
        if (m_hold[i])
          check($sformatf("out_ovf[%0d]", i), {71'b0, d_ovf[i]}, {71'b0, m_hovf[i]});
      end
    end
  end

  task automatic step(input bit v, input logic [63:0] p, input bit c, input bit r);
    in_valid   = v;
    in_product = p;
    clear      = c;
    out_ready  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_product = '0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 1'b0;
    checking = 1'b1;
    check("rst_valid", {71'b0, d_valid[0]}, 72'd0);
    check("rst_sum", d_sum[0], 72'd0);
    check("rst_count", {64'b0, d_cnt[0]}, 72'd0);
    check("rst_ready", {71'b0, d_ready[0]}, 72'd1);

    // Two-product batch, then backpressure with in_valid held high.
    step(1, 64'h1BB6BAA0, 0, 0);
    step(1, 64'hFFFFFFFF_F7747564, 0, 0);
    check("t1_valid", {71'b0, d_valid[1]}, 72'd1);
    check("t1_sum", d_sum[1], 72'h132B3004);
    check("t1_ovf", {71'b0, d_ovf[1]}, 72'd0);
    check("t1_count", {64'b0, d_cnt[1]}, 72'd2);
    check("t1_sum64", d_sum[2], 72'h132B3004);
    repeat (5) step(1, 64'h55, 0, 0);
    check("t2_sum_stable", d_sum[1], 72'h132B3004);
    check("t2_count_stable", {64'b0, d_cnt[1]}, 72'd2);
    step(0, 0, 0, 1);
    check("t2_released", {71'b0, d_valid[1]}, 72'd0);
    step(1, 64'h10, 0, 0);
    step(1, 64'h20, 0, 0);
    check("t2_fresh_sum", d_sum[1], 72'h30);

    // Overflow at 64-bit accumulator width.
    step(0, 0, 1, 0);
    step(1, 64'h7FFFFFFF_FFFFFFFF, 0, 0);
    step(1, 64'h1, 0, 0);
    check("t3_sum64", d_sum[2], 72'h00_80000000_00000000);
    check("t3_ovf64", {71'b0, d_ovf[2]}, 72'd1);
    check("t3_sum72", d_sum[1], 72'h00_80000000_00000000);
    check("t3_ovf72", {71'b0, d_ovf[1]}, 72'd0);
    step(0, 0, 0, 1);
    step(1, 64'h1, 0, 0);
    step(1, 64'h1, 0, 0);
    check("t3_next_sum", d_sum[2], 72'd2);
    check("t3_next_ovf", {71'b0, d_ovf[2]}, 72'd0);

    // Four -1 products separated by idle gaps.
    step(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 64'hFFFFFFFF_FFFFFFFF, 0, 0);
      check("t4_count", {64'b0, d_cnt[0]}, 72'(k + 1));
      step(0, 0, 0, 0);
      check("t4_count_gap", {64'b0, d_cnt[0]}, 72'(k + 1));
    end
    check("t4_sum", d_sum[0], 72'hFF_FFFFFFFF_FFFFFFFC);
    check("t4_ovf", {71'b0, d_ovf[0]}, 72'd0);

    // clear mid-batch drops the concurrent product; clear in HOLD drops the result.
    step(0, 0, 1, 0);
    step(1, 64'h1, 0, 0);
    step(1, 64'h1, 0, 0);
    step(1, 64'h1, 1, 0);
    check("t5_count_cleared", {64'b0, d_cnt[0]}, 72'd0);
    repeat (4) step(1, 64'h1, 0, 0);
    check("t5_sum", d_sum[0], 72'd4);
    check("t5_valid", {71'b0, d_valid[0]}, 72'd1);
    step(0, 0, 1, 0);
    check("t5_hold_cleared", {71'b0, d_valid[0]}, 72'd0);

    // reset mid-batch and in HOLD, with clear asserted alongside.
    step(1, 64'h5, 0, 0);
    step(1, 64'h5, 0, 0);
    reset = 1'b1;
    step(1, 64'h5, 1, 1);
    reset = 1'b0;
    check("t6_count", {64'b0, d_cnt[0]}, 72'd0);
    check("t6_sum", d_sum[0], 72'd0);
    repeat (4) step(1, 64'h9, 0, 0);
    check("t6_held", {71'b0, d_valid[0]}, 72'd1);
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    check("t6_hold_valid", {71'b0, d_valid[0]}, 72'd0);
    check("t6_hold_sum", d_sum[0], 72'd0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] p;
      case ($urandom_range(0, 3))
        0:       p = 64'h7FFFFFFF_FFFFFFFF;
        1:       p = 64'h80000000_00000000;
        2:       p = {{48{1'b0}}, 16'($urandom)};
        default: p = {$urandom, $urandom};
      endcase
      reset = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 9) < 7, p, $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1);
    end
    reset = 1'b0;
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
